// File: rtl/reg_write_arbiter.sv
// rtl/reg_write_arbiter.sv - two-requester register-file write arbiter with forwarding
module reg_write_arbiter #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [ADDR_W-1:0] req0_addr,
  input  logic [DATA_W-1:0] req0_data,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [ADDR_W-1:0] req1_addr,
  input  logic [DATA_W-1:0] req1_data,
  output logic              RegWre,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] write_data,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic              fwd_hit,
  output logic [DATA_W-1:0] fwd_data,
  output logic [31:0]       pend_mask
);

  typedef enum logic [1:0] {
    AGE_EQ     = 2'd0,
    AGE_B0_OLD = 2'd1,
    AGE_B1_OLD = 2'd2
  } age_t;

  logic              r_v0, r_v1;
  logic [ADDR_W-1:0] r_a0, r_a1;
  logic [DATA_W-1:0] r_d0, r_d1;
  age_t              r_age;
  logic              r_rr;

  logic              w_load0, w_load1;
  logic              w_any, w_both, w_gnt1;
  logic              w_clr0, w_clr1;
  logic              w_nv0, w_nv1;
  age_t              w_age_nxt;
  logic              w_rr_nxt;
  logic              w_hit0, w_hit1, w_use1;

  assign req0_ready = ~r_v0;
  assign req1_ready = ~r_v1;

  // Writes to r0 are accepted but never buffered.
  assign w_load0 = req0_valid & ~r_v0 & (req0_addr != '0);
  assign w_load1 = req1_valid & ~r_v1 & (req1_addr != '0);

  assign w_any  = r_v0 | r_v1;
  assign w_both = r_v0 & r_v1;

  always_comb begin
    w_gnt1 = 1'b0;
    if (r_v1 && !r_v0) begin
      w_gnt1 = 1'b1;
    end else if (w_both) begin
      case (r_age)
        AGE_B0_OLD: w_gnt1 = 1'b0;
        AGE_B1_OLD: w_gnt1 = 1'b1;
        default:    w_gnt1 = (r_a0 == r_a1) ? 1'b0 : r_rr;
      endcase
    end
  end

  assign w_clr0 = r_v0 & ~w_gnt1;
  assign w_clr1 = r_v1 & w_gnt1;
  assign w_nv0  = w_load0 | (r_v0 & ~w_clr0);
  assign w_nv1  = w_load1 | (r_v1 & ~w_clr1);

  always_comb begin
    w_age_nxt = AGE_EQ;
    w_rr_nxt  = r_rr;
    if (w_nv0 && w_nv1) begin
      if (w_load0 && w_load1)  w_age_nxt = AGE_EQ;
      else if (w_load0)        w_age_nxt = AGE_B1_OLD;
      else if (w_load1)        w_age_nxt = AGE_B0_OLD;
      else                     w_age_nxt = r_age;
    end
    if (w_both) begin
      w_rr_nxt = ~w_gnt1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_v0  <= 1'b0;
      r_v1  <= 1'b0;
      r_a0  <= '0;
      r_a1  <= '0;
      r_d0  <= '0;
      r_d1  <= '0;
      r_age <= AGE_EQ;
      r_rr  <= 1'b0;
    end else begin
      r_v0  <= w_nv0;
      r_v1  <= w_nv1;
      if (w_load0) begin
        r_a0 <= req0_addr;
        r_d0 <= req0_data;
      end
      if (w_load1) begin
        r_a1 <= req1_addr;
        r_d1 <= req1_data;
      end
      r_age <= w_age_nxt;
      r_rr  <= w_rr_nxt;
    end
  end

  assign RegWre     = w_any;
  assign wr_addr    = !w_any ? '0 : (w_gnt1 ? r_a1 : r_a0);
  assign write_data = !w_any ? '0 : (w_gnt1 ? r_d1 : r_d0);

  assign w_hit0 = r_v0 && (r_a0 == rd_addr) && (rd_addr != '0);
  assign w_hit1 = r_v1 && (r_a1 == rd_addr) && (rd_addr != '0);
  // On a double hit the younger entry wins; buffer 1 breaks an age tie.
  assign w_use1 = (r_age != AGE_B1_OLD);

  always_comb begin
    fwd_hit  = w_hit0 | w_hit1;
    fwd_data = '0;
    if (w_hit1 && (!w_hit0 || w_use1)) fwd_data = r_d1;
    else if (w_hit0)                   fwd_data = r_d0;
  end

  always_comb begin
    pend_mask = 32'd0;
    if (r_v0) pend_mask = pend_mask | (32'd1 << r_a0);
    if (r_v1) pend_mask = pend_mask | (32'd1 << r_a1);
    pend_mask[0] = 1'b0;
  end

endmodule

// File: tb/tb_reg_write_arbiter.sv
// tb/tb_reg_write_arbiter.sv - directed and randomized checks of reg_write_arbiter
module tb_reg_write_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req0_valid = 1'b0, req1_valid = 1'b0;
  logic        req0_ready, req1_ready;
  logic [4:0]  req0_addr = '0, req1_addr = '0, rd_addr = '0;
  logic [31:0] req0_data = '0, req1_data = '0;
  logic        RegWre, fwd_hit;
  logic [4:0]  wr_addr;
  logic [31:0] write_data, fwd_data, pend_mask;

  int n_total = 0;
  int n_bad   = 0;

  bit          m_v[2];
  logic [4:0]  m_a[2];
  logic [31:0] m_d[2];
  int          m_t[2];
  bit          m_rr;
  int          edge_no;

  reg_write_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_addr(req0_addr), .req0_data(req0_data),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_addr(req1_addr), .req1_data(req1_data),
    .RegWre(RegWre), .wr_addr(wr_addr), .write_data(write_data),
    .rd_addr(rd_addr), .fwd_hit(fwd_hit), .fwd_data(fwd_data), .pend_mask(pend_mask)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_idle(input string tag);
    chk({tag, "_wre"}, RegWre, 0);
    chk({tag, "_waddr"}, wr_addr, 0);
    chk({tag, "_wdata"}, write_data, 0);
    chk({tag, "_rdy0"}, req0_ready, 1);
    chk({tag, "_rdy1"}, req1_ready, 1);
    chk({tag, "_pend"}, pend_mask, 0);
    chk({tag, "_fhit"}, fwd_hit, 0);
    chk({tag, "_fdata"}, fwd_data, 0);
  endtask

  task automatic check_write(input string tag, input logic [4:0] a, input logic [31:0] d);
    chk({tag, "_wre"}, RegWre, 1);
    chk({tag, "_waddr"}, wr_addr, a);
    chk({tag, "_wdata"}, write_data, d);
  endtask

  // Grant by load order; ties go to buffer 0 on matching addresses, else to rr.
  function automatic int m_grant();
    if (!m_v[0] && !m_v[1]) return -1;
    if (!m_v[1]) return 0;
    if (!m_v[0]) return 1;
    if (m_t[0] < m_t[1]) return 0;
    if (m_t[1] < m_t[0]) return 1;
    if (m_a[0] == m_a[1]) return 0;
    return m_rr ? 1 : 0;
  endfunction

  task automatic model_clear();
    m_v[0] = 0; m_v[1] = 0;
    m_rr = 0;
  endtask

  task automatic model_check();
    int g;
    bit h0, h1;
    logic [31:0] mask, fd;
    g = m_grant();
    mask = 0;
    for (int i = 0; i < 2; i++) if (m_v[i]) mask[m_a[i]] = 1'b1;
    mask[0] = 1'b0;
    h0 = m_v[0] && m_a[0] == rd_addr && rd_addr != 0;
    h1 = m_v[1] && m_a[1] == rd_addr && rd_addr != 0;
    fd = 0;
    if (h0 && h1) fd = (m_t[0] > m_t[1]) ? m_d[0] : m_d[1];
    else if (h0)  fd = m_d[0];
    else if (h1)  fd = m_d[1];
    chk("rnd_wre", RegWre, g >= 0);
    chk("rnd_waddr", wr_addr, (g >= 0) ? m_a[g] : 5'd0);
    chk("rnd_wdata", write_data, (g >= 0) ? m_d[g] : 32'd0);
    chk("rnd_rdy0", req0_ready, !m_v[0]);
    chk("rnd_rdy1", req1_ready, !m_v[1]);
    chk("rnd_pend", pend_mask, mask);
    chk("rnd_fhit", fwd_hit, h0 || h1);
    chk("rnd_fdata", fwd_data, fd);
  endtask

  task automatic model_edge();
    int g;
    bit both, acc0, acc1;
    g = m_grant();
    both = m_v[0] && m_v[1];
    acc0 = req0_valid && !m_v[0];
    acc1 = req1_valid && !m_v[1];
    if (g >= 0) m_v[g] = 0;
    if (both) m_rr = (g == 0);
    if (acc0 && req0_addr != 0) begin
      m_v[0] = 1; m_a[0] = req0_addr; m_d[0] = req0_data; m_t[0] = edge_no;
    end
    if (acc1 && req1_addr != 0) begin
      m_v[1] = 1; m_a[1] = req1_addr; m_d[1] = req1_data; m_t[1] = edge_no;
    end
    edge_no++;
  endtask

  initial begin
    // Reset state, with a request held that must not be taken.
    req0_valid = 1; req0_addr = 5; req0_data = 32'h77;
    #2;
    check_idle("rst");
    step();
    req0_valid = 0;
    rst_n = 1;
    #1;
    check_idle("rst_rel");

    // Single uncontested write.
    req0_valid = 1; req0_addr = 5; req0_data = 32'hA5; rd_addr = 5;
    step();
    req0_valid = 0;
    #1;
    check_write("single", 5, 32'hA5);
    chk("single_rdy0", req0_ready, 0);
    chk("single_pend", pend_mask, 32'h20);
    chk("single_fhit", fwd_hit, 1);
    chk("single_fdata", fwd_data, 32'hA5);
    step();
    check_idle("single_done");

    // Simultaneous load, rr=0: buffer 0 first.
    req0_valid = 1; req0_addr = 3; req0_data = 32'h11;
    req1_valid = 1; req1_addr = 4; req1_data = 32'h22;
    step();
    req0_valid = 0; req1_valid = 0;
    #1;
    check_write("simul_a", 3, 32'h11);
    chk("simul_pend", pend_mask, 32'h18);
    step();
    check_write("simul_b", 4, 32'h22);
    step();
    chk("simul_idle", RegWre, 0);

    // rr now favours requester 1; buffer 0 is held and backpressures.
    req0_valid = 1; req0_addr = 12; req0_data = 32'h1;
    req1_valid = 1; req1_addr = 13; req1_data = 32'h2;
    step();
    req1_valid = 0;
    req0_addr = 14; req0_data = 32'h3;
    #1;
    check_write("bp_1", 13, 32'h2);
    chk("bp_rdy0_a", req0_ready, 0);
    step();
    check_write("bp_2", 12, 32'h1);
    chk("bp_rdy0_b", req0_ready, 0);
    step();
    chk("bp_rdy0_c", req0_ready, 1);
    chk("bp_wre_gap", RegWre, 0);
    step();
    req0_valid = 0;
    #1;
    check_write("bp_3", 14, 32'h3);
    step();
    chk("bp_idle", RegWre, 0);

    // Equal age, equal address: buffer 0 first, forward shows buffer 1.
    req0_valid = 1; req0_addr = 9; req0_data = 32'h90;
    req1_valid = 1; req1_addr = 9; req1_data = 32'h91; rd_addr = 9;
    step();
    req0_valid = 0; req1_valid = 0;
    #1;
    check_write("eqaddr_a", 9, 32'h90);
    chk("eqaddr_fdata", fwd_data, 32'h91);
    step();
    check_write("eqaddr_b", 9, 32'h91);
    step();

    // Same address from both requesters on different edges.
    req1_valid = 1; req1_addr = 7; req1_data = 32'hB; rd_addr = 7;
    step();
    req1_valid = 0;
    req0_valid = 1; req0_addr = 7; req0_data = 32'hC;
    #1;
    check_write("order_a", 7, 32'hB);
    chk("order_fd_a", fwd_data, 32'hB);
    step();
    req0_valid = 0;
    #1;
    check_write("order_b", 7, 32'hC);
    chk("order_fhit", fwd_hit, 1);
    chk("order_fd_b", fwd_data, 32'hC);
    step();

    // r0 discard.
    req1_valid = 1; req1_addr = 0; req1_data = 32'hFFFF; rd_addr = 0;
    step();
    req1_valid = 0;
    #1;
    check_idle("r0");

    // Reset with both buffers valid.
    req0_valid = 1; req0_addr = 20; req0_data = 32'h5;
    req1_valid = 1; req1_addr = 21; req1_data = 32'h6; rd_addr = 20;
    step();
    req0_addr = 22;
    req1_valid = 0;
    #1;
    chk("mid_wre_pre", RegWre, 1);
    rst_n = 0;
    #1;
    check_idle("mid_rst");
    step();
    rst_n = 1;
    req0_valid = 0;
    #1;
    check_idle("mid_rel");
    step();
    check_idle("mid_after");

    // Randomized phase against the reference model.
    model_clear();
    edge_no = 0;
    for (int c = 0; c < 2000; c++) begin
      req0_valid = ($urandom_range(0, 99) < 55);
      req0_addr  = 5'($urandom_range(0, 7));
      req0_data  = $urandom;
      req1_valid = ($urandom_range(0, 99) < 55);
      req1_addr  = 5'($urandom_range(0, 7));
      req1_data  = $urandom;
      rd_addr    = 5'($urandom_range(0, 7));
      #1;
      if ($urandom_range(0, 99) == 0) begin
        rst_n = 0;
        #1;
        model_clear();
        model_check();
        step();
        rst_n = 1;
        #1;
        model_check();
      end else begin
        model_check();
        @(posedge clk);
        model_edge();
        #1;
      end
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
